// File: rtl/qspi_cache_pkg.sv
// Shared types and helpers for the QSPI read-only line cache.
// Lines are 128 bits wide; flash order puts word 0 in the most significant bits.
package qspi_cache_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} cache_state_t;

  localparam int LINE_BITS   = 128;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 4;

  function automatic logic [WORD_BITS-1:0] word_sel(input logic [LINE_BITS-1:0] line,
                                                    input logic [1:0]           sel);
    logic [WORD_BITS-1:0] w;
    case (sel)
      2'd0:    w = line[127:96];
      2'd1:    w = line[95:64];
      2'd2:    w = line[63:32];
      default: w = line[31:0];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/qspi_line_cache_if.sv
// CPU fetch port and QSPI fill port of the line cache.
// Handshakes: a request transfers on the cycle where req_valid & req_ready are both high;
// rsp_valid is a single-cycle pulse; qspi_read_en pulses only while qspi_rready is high;
// qspi_dval is a single-cycle pulse carrying a complete line on qspi_dout.
interface qspi_line_cache_if;
  import qspi_cache_pkg::*;

  logic                 req_valid;
  logic [31:0]          req_addr;
  logic                 req_ready;
  logic                 rsp_valid;
  logic [WORD_BITS-1:0] rsp_data;
  logic [31:0]          qspi_addr;
  logic                 qspi_read_en;
  logic                 qspi_rready;
  logic [LINE_BITS-1:0] qspi_dout;
  logic                 qspi_dval;

  modport slave (
    input  req_valid, req_addr, qspi_rready, qspi_dout, qspi_dval,
    output req_ready, rsp_valid, rsp_data, qspi_addr, qspi_read_en
  );

  modport master (
    output req_valid, req_addr, qspi_rready, qspi_dout, qspi_dval,
    input  req_ready, rsp_valid, rsp_data, qspi_addr, qspi_read_en
  );

endinterface

// File: rtl/qspi_cache_array.sv
// Direct-mapped valid/tag/data storage with a combinational lookup port,
// a single line write port and a whole-array flush.
module qspi_cache_array
  import qspi_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IDX_W = $clog2(LINES),
  parameter int TAG_W = 32 - OFFSET_BITS - IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [IDX_W-1:0]     lk_idx,
  input  logic [TAG_W-1:0]     lk_tag,
  output logic                 lk_hit,
  output logic [LINE_BITS-1:0] lk_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [LINES-1:0]     valid_q;
  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];

  // Flush has priority so a line filled in the flush cycle stays invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_line = data_q[lk_idx];

endmodule

// File: rtl/qspi_line_cache.sv
// Direct-mapped read-only line cache in front of the QSPI read engine.
// Hits answer one cycle after acceptance; misses fetch a full 128-bit line first.
module qspi_line_cache
  import qspi_cache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  qspi_line_cache_if.slave       bus,
  output logic [CNT_W-1:0]       hit_cnt,
  output logic [CNT_W-1:0]       miss_cnt,
  output cache_state_t           state
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - OFFSET_BITS - IDX_W;

  cache_state_t         state_q, state_d;
  logic [31:2]          addr_q;
  logic                 lk_hit;
  logic [LINE_BITS-1:0] lk_line;
  logic                 accept;
  logic                 fill_we;
  logic                 rsp_valid_q;
  logic [WORD_BITS-1:0] rsp_data_q;
  logic                 unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign accept  = bus.req_valid && (state_q == IDLE);
  assign fill_we = (state_q == WAIT) && bus.qspi_dval;

  qspi_cache_array #(.LINES(LINES), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .lk_idx  (bus.req_addr[OFFSET_BITS +: IDX_W]),
    .lk_tag  (bus.req_addr[31 -: TAG_W]),
    .lk_hit  (lk_hit),
    .lk_line (lk_line),
    .wr_en   (fill_we),
    .wr_idx  (addr_q[OFFSET_BITS +: IDX_W]),
    .wr_tag  (addr_q[31 -: TAG_W]),
    .wr_data (bus.qspi_dout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    bus.req_ready    = 1'b0;
    bus.qspi_read_en = 1'b0;
    bus.qspi_addr    = {addr_q[31:4], 4'h0};
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept && !lk_hit) state_d = ISSUE;
      end
      ISSUE: begin
        // The engine only samples read_en while idle, so the pulse waits for rready.
        if (bus.qspi_rready) begin
          bus.qspi_read_en = 1'b1;
          state_d          = WAIT;
        end
      end
      WAIT:    if (bus.qspi_dval) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (accept && lk_hit) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= word_sel(lk_line, bus.req_addr[3:2]);
        if (hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
      end
      if (accept && !lk_hit) begin
        addr_q <= bus.req_addr[31:2];
        if (miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
      end
      if (fill_we) begin
        rsp_valid_q <= 1'b1;
        rsp_data_q  <= word_sel(bus.qspi_dout, addr_q[3:2]);
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign state         = state_q;

endmodule

// File: tb/tb_qspi_line_cache.sv
// Directed bench for qspi_line_cache: reset, miss/hit, conflict, backpressure,
// flush collisions, reset mid-fill and counter saturation (CNT_W shrunk to 4).
module tb_qspi_line_cache;
  import qspi_cache_pkg::*;

  localparam int CNT_W = 4;
  localparam logic [127:0] LINE_A = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] LINE_B = 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  cache_state_t     state;
  int               test_cnt = 0;
  int               fail_cnt = 0;
  logic [31:0]      exp_q[$];

  qspi_line_cache_if bus();

  qspi_line_cache #(.LINES(8), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .state    (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [31:0] addr, output logic ready_seen);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    #1;
    ready_seen = bus.req_ready;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_read_en(input int max, output int waited, output logic [31:0] addr_seen);
    int n = 0;
    while (n < max && !bus.qspi_read_en) begin
      step();
      n++;
    end
    waited    = bus.qspi_read_en ? n : -1;
    addr_seen = bus.qspi_addr;
  endtask

  // Called in the read_en cycle; dval arrives dly cycles later, ends on the response cycle.
  task automatic fill(input logic [127:0] line, input int dly, input logic fl, output int extra_en);
    extra_en = 0;
    for (int i = 0; i < dly; i++) begin
      step();
      if (bus.qspi_read_en) extra_en++;
    end
    bus.qspi_dval = 1'b1;
    bus.qspi_dout = line;
    flush         = fl;
    step();
    bus.qspi_dval = 1'b0;
    flush         = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic rdy;
    rst = 1'b0;
    step();
    step();
    test_cnt++; if (state !== IDLE) begin fail_cnt++; $display("FAIL reset_state got %0d want %0d", state, IDLE); end
    test_cnt++; if (bus.rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
    test_cnt++; if (bus.rsp_data !== 32'h0) begin fail_cnt++; $display("FAIL reset_rsp_data got %h want 0", bus.rsp_data); end
    test_cnt++; if (bus.qspi_read_en !== 1'b0 || bus.qspi_addr !== 32'h0) begin fail_cnt++; $display("FAIL reset_qspi got en=%0b addr=%h want 0/0", bus.qspi_read_en, bus.qspi_addr); end
    test_cnt++; if (hit_cnt !== '0 || miss_cnt !== '0) begin fail_cnt++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    rst = 1'b1;
    step();
    rdy = bus.req_ready;
    test_cnt++; if (rdy !== 1'b1) begin fail_cnt++; $display("FAIL reset_req_ready got %0b want 1", rdy); end
  endtask

  task automatic test_cold_miss();
    logic rdy; int w; logic [31:0] a; int extra;
    send_req(32'h0000_0104, rdy);
    test_cnt++; if (rdy !== 1'b1) begin fail_cnt++; $display("FAIL cold_req_ready got %0b want 1", rdy); end
    wait_read_en(20, w, a);
    test_cnt++; if (w !== 0) begin fail_cnt++; $display("FAIL cold_read_en_delay got %0d want 0", w); end
    test_cnt++; if (a !== 32'h0000_0100) begin fail_cnt++; $display("FAIL cold_qspi_addr got %h want 00000100", a); end
    fill(LINE_A, 5, 1'b0, extra);
    test_cnt++; if (extra !== 0) begin fail_cnt++; $display("FAIL cold_single_pulse got %0d extra want 0", extra); end
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h2222_2222) begin fail_cnt++; $display("FAIL cold_rsp got v=%0b d=%h want 1/22222222", bus.rsp_valid, bus.rsp_data); end
    test_cnt++; if (miss_cnt !== 4'd1) begin fail_cnt++; $display("FAIL cold_miss_cnt got %0d want 1", miss_cnt); end
    step();
    test_cnt++; if (bus.rsp_valid !== 1'b0 || state !== IDLE) begin fail_cnt++; $display("FAIL cold_after got v=%0b st=%0d want 0/IDLE", bus.rsp_valid, state); end
  endtask

  task automatic test_hit();
    logic rdy;
    send_req(32'h0000_010C, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h4444_4444) begin fail_cnt++; $display("FAIL hit_rsp got v=%0b d=%h want 1/44444444", bus.rsp_valid, bus.rsp_data); end
    test_cnt++; if (bus.qspi_read_en !== 1'b0 || state !== IDLE) begin fail_cnt++; $display("FAIL hit_no_fill got en=%0b st=%0d want 0/IDLE", bus.qspi_read_en, state); end
    test_cnt++; if (hit_cnt !== 4'd1) begin fail_cnt++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
    step();
    test_cnt++; if (bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h4444_4444) begin fail_cnt++; $display("FAIL hit_hold got v=%0b d=%h want 0/44444444", bus.rsp_valid, bus.rsp_data); end
  endtask

  task automatic test_conflict();
    logic rdy; int w; logic [31:0] a; int extra;
    send_req(32'h0000_0184, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL conflict_miss got v=%0b want 0", bus.rsp_valid); end
    wait_read_en(20, w, a);
    test_cnt++; if (w < 0 || a !== 32'h0000_0180) begin fail_cnt++; $display("FAIL conflict_fill got w=%0d addr=%h want addr 00000180", w, a); end
    fill(LINE_B, 3, 1'b0, extra);
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hBBBB_1111) begin fail_cnt++; $display("FAIL conflict_rsp got v=%0b d=%h want 1/bbbb1111", bus.rsp_valid, bus.rsp_data); end
    step();
    send_req(32'h0000_0104, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b0 || state !== ISSUE) begin fail_cnt++; $display("FAIL conflict_evicted got v=%0b st=%0d want 0/ISSUE", bus.rsp_valid, state); end
    wait_read_en(20, w, a);
    test_cnt++; if (w < 0 || a !== 32'h0000_0100) begin fail_cnt++; $display("FAIL conflict_refill got w=%0d addr=%h want addr 00000100", w, a); end
    fill(LINE_A, 2, 1'b0, extra);
    test_cnt++; if (bus.rsp_data !== 32'h2222_2222 || miss_cnt !== 4'd3) begin fail_cnt++; $display("FAIL conflict_rerun got d=%h miss=%0d want 22222222/3", bus.rsp_data, miss_cnt); end
    step();
  endtask

  task automatic test_backpressure();
    logic rdy; int bad; int extra;
    bad = 0;
    bus.qspi_rready = 1'b0;
    send_req(32'h0000_0204, rdy);
    for (int i = 0; i < 10; i++) begin
      if (bus.qspi_read_en !== 1'b0 || bus.req_ready !== 1'b0) bad++;
      step();
    end
    test_cnt++; if (bad !== 0 || state !== ISSUE) begin fail_cnt++; $display("FAIL bp_hold got bad=%0d st=%0d want 0/ISSUE", bad, state); end
    bus.qspi_rready = 1'b1;
    #1;
    test_cnt++; if (bus.qspi_read_en !== 1'b1 || bus.qspi_addr !== 32'h0000_0200) begin fail_cnt++; $display("FAIL bp_release got en=%0b addr=%h want 1/00000200", bus.qspi_read_en, bus.qspi_addr); end
    fill(LINE_B, 4, 1'b0, extra);
    test_cnt++; if (extra !== 0 || bus.rsp_data !== 32'hBBBB_1111) begin fail_cnt++; $display("FAIL bp_rsp got extra=%0d d=%h want 0/bbbb1111", extra, bus.rsp_data); end
    step();
    send_req(32'h0000_0208, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hCCCC_2222 || hit_cnt !== 4'd2) begin fail_cnt++; $display("FAIL bp_hit got v=%0b d=%h hits=%0d want 1/cccc2222/2", bus.rsp_valid, bus.rsp_data, hit_cnt); end
    step();
  endtask

  task automatic test_flush();
    logic rdy; int w; logic [31:0] a; int extra;
    send_req(32'h0000_0304, rdy);
    wait_read_en(20, w, a);
    fill(LINE_A, 3, 1'b1, extra);
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h2222_2222) begin fail_cnt++; $display("FAIL flush_fill_rsp got v=%0b d=%h want 1/22222222", bus.rsp_valid, bus.rsp_data); end
    step();
    send_req(32'h0000_0304, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b0 || state !== ISSUE) begin fail_cnt++; $display("FAIL flush_fill_remiss got v=%0b st=%0d want 0/ISSUE", bus.rsp_valid, state); end
    wait_read_en(20, w, a);
    fill(LINE_B, 3, 1'b0, extra);
    step();
    flush = 1'b1;
    send_req(32'h0000_030C, rdy);
    flush = 1'b0;
    test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hDDDD_3333) begin fail_cnt++; $display("FAIL flush_idle_hit got v=%0b d=%h want 1/dddd3333", bus.rsp_valid, bus.rsp_data); end
    step();
    send_req(32'h0000_030C, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b0 || state !== ISSUE) begin fail_cnt++; $display("FAIL flush_idle_after got v=%0b st=%0d want 0/ISSUE", bus.rsp_valid, state); end
    wait_read_en(20, w, a);
    fill(LINE_B, 1, 1'b0, extra);
    test_cnt++; if (hit_cnt !== 4'd3 || miss_cnt !== 4'd7) begin fail_cnt++; $display("FAIL flush_counters got %0d/%0d want 3/7", hit_cnt, miss_cnt); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    logic rdy; int w; logic [31:0] a; int extra;
    send_req(32'h0000_0404, rdy);
    wait_read_en(20, w, a);
    step();
    test_cnt++; if (state !== WAIT) begin fail_cnt++; $display("FAIL rmw_in_wait got %0d want %0d", state, WAIT); end
    rst = 1'b0;
    #1;
    test_cnt++; if (state !== IDLE || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'h0) begin fail_cnt++; $display("FAIL rmw_async got st=%0d v=%0b d=%h want IDLE/0/0", state, bus.rsp_valid, bus.rsp_data); end
    test_cnt++; if (bus.qspi_addr !== 32'h0 || hit_cnt !== '0 || miss_cnt !== '0) begin fail_cnt++; $display("FAIL rmw_zero got addr=%h hits=%0d miss=%0d want 0/0/0", bus.qspi_addr, hit_cnt, miss_cnt); end
    step();
    rst = 1'b1;
    step();
    bus.qspi_dval = 1'b1;
    bus.qspi_dout = LINE_B;
    step();
    bus.qspi_dval = 1'b0;
    test_cnt++; if (bus.rsp_valid !== 1'b0 || state !== IDLE) begin fail_cnt++; $display("FAIL rmw_stray_dval got v=%0b st=%0d want 0/IDLE", bus.rsp_valid, state); end
    send_req(32'h0000_0104, rdy);
    test_cnt++; if (bus.rsp_valid !== 1'b0 || miss_cnt !== 4'd1) begin fail_cnt++; $display("FAIL rmw_remiss got v=%0b miss=%0d want 0/1", bus.rsp_valid, miss_cnt); end
    wait_read_en(20, w, a);
    test_cnt++; if (w < 0 || a !== 32'h0000_0100) begin fail_cnt++; $display("FAIL rmw_fill got w=%0d addr=%h want addr 00000100", w, a); end
    fill(LINE_A, 2, 1'b0, extra);
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [31:0] exp_w;
    int bad_en;
    words  = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    bad_en = 0;
    for (int i = 0; i < 20; i++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0000_0100 + 32'(4 * (i % 4));
      exp_q.push_back(words[i % 4]);
      step();
      exp_w = exp_q.pop_front();
      if (bus.qspi_read_en !== 1'b0) bad_en++;
      test_cnt++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_w) begin fail_cnt++; $display("FAIL b2b_rsp[%0d] got v=%0b d=%h want 1/%h", i, bus.rsp_valid, bus.rsp_data, exp_w); end
    end
    bus.req_valid = 1'b0;
    step();
    test_cnt++; if (bad_en !== 0 || bus.rsp_valid !== 1'b0) begin fail_cnt++; $display("FAIL b2b_quiet got en=%0d v=%0b want 0/0", bad_en, bus.rsp_valid); end
    test_cnt++; if (hit_cnt !== 4'hF || miss_cnt !== 4'd1) begin fail_cnt++; $display("FAIL b2b_saturate got hits=%0d miss=%0d want 15/1", hit_cnt, miss_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst             = 1'b0;
    flush           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.qspi_rready = 1'b1;
    bus.qspi_dout   = '0;
    bus.qspi_dval   = 1'b0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_flush();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
